param_demux_reg: RTL and testbench

Registered, parameterised demultiplexer that routes one WIDTH-bit word stream into N independent holding registers. It is the write-side counterpart of the N-to-1 `param_mux` read path: pulse-width measurements are steered into per-channel slots by `sel`, and each slot holds its word and a valid flag until the consumer acknowledges it. Per-channel sticky overflow flags report words that arrive while a slot is still occupied.

---
 rtl/param_demux_pkg.sv | 11 +
 rtl/demux_slot.sv | 64 ++++++
 rtl/param_demux_reg.sv | 66 ++++++
 tb/tb_param_demux_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/param_demux_pkg.sv
// Shared definitions for the registered demultiplexer and its param_mux counterparts:
// default geometry and the channel-index type.
package param_demux_pkg;

    localparam int unsigned DefaultN        = 4;
    localparam int unsigned DefaultWidth    = 8;
    localparam int unsigned DefaultSelWidth = $clog2(DefaultN);

    typedef logic [DefaultSelWidth-1:0] chan_idx_t;

endpackage

// File: rtl/demux_slot.sv
// One demux channel: a held data word, its valid flag and a sticky overflow flag.
// Build option PARAM_DEMUX_OVERWRITE_EN: a write into a full slot replaces the held word
// (newest-wins); without it the held word is kept (oldest-wins). Overflow is flagged either way.
module demux_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ack,
    input  logic             clr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             ovf
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             full;
    logic             ovf_event;

    // A slot being acked this cycle counts as free, so write+ack never overflows.
    assign full      = valid_q && !ack;
    assign ovf_event = wr && full;

    // Next-state: write beats ack; overflow set beats clear.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr) begin
            valid_d = 1'b1;
`ifdef PARAM_DEMUX_OVERWRITE_EN
            data_d = data_in;
`else
            if (!full) begin
                data_d = data_in;
            end
`endif
        end else if (ack) begin
            valid_d = 1'b0;
        end
        ovf_d = ovf_event || (ovf_q && !clr);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign ovf      = ovf_q;

endmodule

// File: rtl/param_demux_reg.sv
// Registered 1-to-N demultiplexer: steers each presented word into the slot chosen by sel,
// where it is held with a valid flag until acknowledged. Out-of-range selects are dropped
// and flagged on sel_err. Build option PARAM_DEMUX_OVERWRITE_EN selects newest-wins on
// overflow (default: oldest-wins); see demux_slot.
module param_demux_reg
    import param_demux_pkg::*;
#(
    parameter int unsigned N         = DefaultN,
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter int unsigned SEL_WIDTH = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic [WIDTH-1:0]     data_in,
    output logic [N*WIDTH-1:0]   data_out,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ack,
    output logic [N-1:0]         overflow,
    input  logic                 ovf_clr,
    output logic                 sel_err
);

    logic [N-1:0] wr;
    logic         bad_sel;
    logic         sel_err_q, sel_err_d;

    // Only reachable when N is not a power of two.
    assign bad_sel = in_valid && (32'(sel) >= N);

    for (genvar i = 0; i < N; i++) begin : g_slot
        assign wr[i] = in_valid && (32'(sel) == i);

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr[i]),
            .data_in  (data_in),
            .ack      (out_ack[i]),
            .clr      (ovf_clr),
            .data_out (data_out[i*WIDTH +: WIDTH]),
            .valid    (out_valid[i]),
            .ovf      (overflow[i])
        );
    end

    // Sticky bad-select flag; a new event wins over a clear in the same cycle.
    always_comb begin
        sel_err_d = bad_sel || (sel_err_q && !ovf_clr);
    end

    // Bad-select flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_param_demux_reg.sv
// Self-checking bench: an N=4 and an N=3 instance share one stimulus stream and are
// compared each cycle against a slot-level reference model, plus directed literal checks.
module tb_param_demux_reg;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  sel;
    logic [7:0]  data_in;
    logic [3:0]  ack;
    logic        ovf_clr;

    logic [31:0] dout4;
    logic [3:0]  ov4, of4;
    logic        err4;
    logic [23:0] dout3;
    logic [2:0]  ov3, of3;
    logic        err3;

    int errors = 0;
    int checks = 0;

    // Reference state: index 0 models the N=4 instance, index 1 the N=3 instance.
    logic [7:0] m_data  [2][4];
    logic       m_valid [2][4];
    logic       m_ovf   [2][4];
    logic       m_err   [2];

    always #5 clk = ~clk;

    param_demux_reg #(.N(4), .WIDTH(W)) u_dut4 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .sel (sel), .data_in (data_in),
        .data_out (dout4), .out_valid (ov4), .out_ack (ack), .overflow (of4),
        .ovf_clr (ovf_clr), .sel_err (err4)
    );

    param_demux_reg #(.N(3), .WIDTH(W)) u_dut3 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .sel (sel), .data_in (data_in),
        .data_out (dout3), .out_valid (ov3), .out_ack (ack[2:0]), .overflow (of3),
        .ovf_clr (ovf_clr), .sel_err (err3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Apply the rules of one clock edge to model m with n channels.
    task automatic model_edge(input int m, input int n);
        bit occupied;
        bit hit;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_data[m][c]  = '0;
                m_valid[m][c] = 1'b0;
                m_ovf[m][c]   = 1'b0;
            end
            m_err[m] = 1'b0;
            return;
        end
        for (int c = 0; c < n; c++) begin
            hit      = in_valid && (int'(sel) == c);
            occupied = m_valid[m][c] && !ack[c];
            if (hit && occupied) begin
                m_ovf[m][c] = 1'b1;
`ifdef PARAM_DEMUX_OVERWRITE_EN
                m_data[m][c] = data_in;
`endif
            end else begin
                if (ovf_clr) m_ovf[m][c] = 1'b0;
                if (hit) begin
                    m_data[m][c]  = data_in;
                    m_valid[m][c] = 1'b1;
                end else if (ack[c]) begin
                    m_valid[m][c] = 1'b0;
                end
            end
        end
        if (in_valid && int'(sel) >= n) m_err[m] = 1'b1;
        else if (ovf_clr)               m_err[m] = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input int m, input int n);
        logic [31:0] r = '0;
        for (int c = 0; c < n; c++) r[c*8 +: 8] = m_data[m][c];
        return r;
    endfunction

    function automatic logic [3:0] exp_bits(input int m, input int n, input bit ovf);
        logic [3:0] r = '0;
        for (int c = 0; c < n; c++) r[c] = ovf ? m_ovf[m][c] : m_valid[m][c];
        return r;
    endfunction

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge(0, 4);
        model_edge(1, 3);
        #1;
        check("n4_data",     64'(dout4), 64'(exp_data(0, 4)));
        check("n4_valid",    64'(ov4),   64'(exp_bits(0, 4, 1'b0)));
        check("n4_overflow", 64'(of4),   64'(exp_bits(0, 4, 1'b1)));
        check("n4_sel_err",  64'(err4),  64'(m_err[0]));
        check("n3_data",     64'(dout3), 64'(exp_data(1, 3)));
        check("n3_valid",    64'(ov3),   64'(exp_bits(1, 3, 1'b0)));
        check("n3_overflow", 64'(of3),   64'(exp_bits(1, 3, 1'b1)));
        check("n3_sel_err",  64'(err3),  64'(m_err[1]));
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] a, input logic c);
        in_valid = v; sel = s; data_in = d; ack = a; ovf_clr = c;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 2'd1, 8'hEE, 4'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            m_data[0][c] = 'x; m_valid[0][c] = 'x; m_ovf[0][c] = 'x;
            m_data[1][c] = 'x; m_valid[1][c] = 'x; m_ovf[1][c] = 'x;
        end

        // Reset held two cycles with a word presented.
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
        step();
        check("reset_data",  64'(dout4), 64'h0);
        check("reset_flags", 64'({ov4, of4, err4}), 64'h0);

        // Fill all four slots back to back; sel=3 is out of range for the N=3 instance.
        drive(1'b1, 2'd0, 8'hA0, 4'h0, 1'b0); step();
        drive(1'b1, 2'd1, 8'hB1, 4'h0, 1'b0); step();
        drive(1'b1, 2'd2, 8'hC2, 4'h0, 1'b0); step();
        drive(1'b1, 2'd3, 8'hD3, 4'h0, 1'b0); step();
        check("fill_data",    64'(dout4), 64'hD3C2B1A0);
        check("fill_valid",   64'(ov4),   64'hF);
        check("fill_ovf",     64'(of4),   64'h0);
        check("badsel_err",   64'(err3),  64'h1);
        check("badsel_slots", 64'(dout3), 64'hC2B1A0);

        // Ack slots 0 and 2.
        drive(1'b0, 2'd0, 8'h00, 4'b0101, 1'b0); step();
        check("ack_valid", 64'(ov4),   64'hA);
        check("ack_data",  64'(dout4), 64'hD3C2B1A0);

        // Overflow into slot 1.
        drive(1'b1, 2'd1, 8'h5A, 4'h0, 1'b0); step();
        check("ovf_flag", 64'(of4), 64'h2);
`ifdef PARAM_DEMUX_OVERWRITE_EN
        check("ovf_data", 64'(dout4[15:8]), 64'h5A);
`else
        check("ovf_data", 64'(dout4[15:8]), 64'hB1);
`endif
        drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b1); step();
        check("ovf_clr", 64'({of4, err3}), 64'h0);

        // Refill slot 2, then write+ack it in the same cycle.
        drive(1'b1, 2'd2, 8'hC2, 4'h0, 1'b0); step();
        drive(1'b1, 2'd2, 8'h77, 4'b0100, 1'b0); step();
        check("wrack_data",  64'(dout4[23:16]), 64'h77);
        check("wrack_valid", 64'(ov4[2]), 64'h1);
        check("wrack_ovf",   64'(of4[2]), 64'h0);

        // Randomized traffic, including clears colliding with overflows and mid-run resets.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                  4'($urandom & $urandom), 1'($urandom_range(0, 9) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
